// File: rtl/vslc_timer_bank.sv
// Bank of PLC-style timers (TON / TOF / TP) sharing one power-of-two prescaled base tick.
// The scan engine drives per-channel IN bits, writes mode/preset, and reads Q and ET.
module vslc_timer_bank #(
    parameter int NUM_TIMERS    = 4,
    parameter int TIMER_WIDTH   = 8,
    parameter int TIMER_CLK_DIV = 15
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_TIMERS-1:0]  tmr_in,
    input  logic                   cfg_we,
    input  logic [3:0]             cfg_sel,
    input  logic [1:0]             cfg_mode,
    input  logic [TIMER_WIDTH-1:0] cfg_preset,
    input  logic [3:0]             rd_sel,
    output logic [TIMER_WIDTH-1:0] rd_et,
    output logic [NUM_TIMERS-1:0]  tmr_q,
    output logic                   base_tick
);

    typedef enum logic [1:0] {
        MODE_OFF = 2'd0,
        MODE_TON = 2'd1,
        MODE_TOF = 2'd2,
        MODE_TP  = 2'd3
    } mode_t;

    localparam logic [TIMER_WIDTH-1:0] ET_ONE = TIMER_WIDTH'(1);

    mode_t                  mode    [NUM_TIMERS];
    logic [TIMER_WIDTH-1:0] pt      [NUM_TIMERS];
    logic [TIMER_WIDTH-1:0] et      [NUM_TIMERS];
    logic [TIMER_WIDTH-1:0] et_step [NUM_TIMERS];
    logic [TIMER_WIDTH-1:0] et_nxt  [NUM_TIMERS];
    logic [NUM_TIMERS-1:0]  prev_in;
    logic [NUM_TIMERS-1:0]  running;
    logic [NUM_TIMERS-1:0]  q_reg;
    logic [NUM_TIMERS-1:0]  q_nxt;
    logic [NUM_TIMERS-1:0]  run_nxt;
    logic [NUM_TIMERS-1:0]  wr_hit;

    generate
        if (TIMER_CLK_DIV == 0) begin : g_no_div
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    base_tick <= 1'b0;
                end else begin
                    base_tick <= 1'b1;
                end
            end
        end else begin : g_div
            logic [TIMER_CLK_DIV-1:0] div_cnt;

            // The tick is registered off the all-ones count, so it lands one cycle after the wrap point.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    div_cnt   <= '0;
                    base_tick <= 1'b0;
                end else begin
                    div_cnt   <= div_cnt + TIMER_CLK_DIV'(1);
                    base_tick <= &div_cnt;
                end
            end
        end
    endgenerate

    // Out-of-range selects never match a channel index, so such writes fall away naturally.
    always_comb begin
        wr_hit = '0;
        for (int i = 0; i < NUM_TIMERS; i++) begin
            wr_hit[i] = cfg_we && (cfg_sel == 4'(i));
        end
    end

    always_comb begin
        q_nxt   = q_reg;
        run_nxt = running;
        for (int i = 0; i < NUM_TIMERS; i++) begin
            et_step[i] = (base_tick && (et[i] < pt[i])) ? et[i] + ET_ONE : et[i];
            et_nxt[i]  = et[i];
            case (mode[i])
                MODE_TON: begin
                    run_nxt[i] = 1'b0;
                    if (!tmr_in[i]) begin
                        et_nxt[i] = '0;
                        q_nxt[i]  = 1'b0;
                    end else begin
                        et_nxt[i] = et_step[i];
                        q_nxt[i]  = (et_step[i] == pt[i]);
                    end
                end
                MODE_TOF: begin
                    run_nxt[i] = 1'b0;
                    if (tmr_in[i]) begin
                        et_nxt[i] = '0;
                        q_nxt[i]  = 1'b1;
                    end else if (q_reg[i]) begin
                        et_nxt[i] = et_step[i];
                        q_nxt[i]  = (et_step[i] != pt[i]);
                    end
                end
                MODE_TP: begin
                    if (running[i]) begin
                        et_nxt[i] = et_step[i];
                        if (et_step[i] == pt[i]) begin
                            q_nxt[i]   = 1'b0;
                            run_nxt[i] = 1'b0;
                        end else begin
                            q_nxt[i] = 1'b1;
                        end
                    end else if (tmr_in[i] && !prev_in[i] && (pt[i] != '0)) begin
                        et_nxt[i]  = '0;
                        q_nxt[i]   = 1'b1;
                        run_nxt[i] = 1'b1;
                    end else begin
                        // A finished pulse keeps ET at PT until IN is released.
                        q_nxt[i] = 1'b0;
                        if (!tmr_in[i]) begin
                            et_nxt[i] = '0;
                        end
                    end
                end
                default: begin
                    et_nxt[i]  = '0;
                    q_nxt[i]   = 1'b0;
                    run_nxt[i] = 1'b0;
                end
            endcase
        end
    end

    // A configuration write wins over any tick or input event on the same channel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_TIMERS; i++) begin
                mode[i] <= MODE_OFF;
                pt[i]   <= '0;
                et[i]   <= '0;
            end
            prev_in <= '0;
            running <= '0;
            q_reg   <= '0;
        end else begin
            for (int i = 0; i < NUM_TIMERS; i++) begin
                if (wr_hit[i]) begin
                    mode[i]    <= mode_t'(cfg_mode);
                    pt[i]      <= cfg_preset;
                    et[i]      <= '0;
                    q_reg[i]   <= 1'b0;
                    running[i] <= 1'b0;
                    prev_in[i] <= 1'b0;
                end else begin
                    et[i]      <= et_nxt[i];
                    q_reg[i]   <= q_nxt[i];
                    running[i] <= run_nxt[i];
                    prev_in[i] <= tmr_in[i];
                end
            end
        end
    end

    always_comb begin
        rd_et = '0;
        for (int i = 0; i < NUM_TIMERS; i++) begin
            if (rd_sel == 4'(i)) begin
                rd_et = et[i];
            end
        end
    end

    assign tmr_q = q_reg;

endmodule

// File: tb/tb_vslc_timer_bank.sv
// Directed bench for vslc_timer_bank with a 4-cycle base tick, 4 channels and 8-bit counters.
module tb_vslc_timer_bank;

    logic       clk;
    logic       rst_n;
    logic [3:0] tmr_in;
    logic       cfg_we;
    logic [3:0] cfg_sel;
    logic [1:0] cfg_mode;
    logic [7:0] cfg_preset;
    logic [3:0] rd_sel;
    logic [7:0] rd_et;
    logic [3:0] tmr_q;
    logic       base_tick;

    int checks;
    int failures;

    vslc_timer_bank #(
        .NUM_TIMERS   (4),
        .TIMER_WIDTH  (8),
        .TIMER_CLK_DIV(2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tmr_in    (tmr_in),
        .cfg_we    (cfg_we),
        .cfg_sel   (cfg_sel),
        .cfg_mode  (cfg_mode),
        .cfg_preset(cfg_preset),
        .rd_sel    (rd_sel),
        .rd_et     (rd_et),
        .tmr_q     (tmr_q),
        .base_tick (base_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [3:0] in_bits);
        tmr_in = in_bits;
        step();
    endtask

    task automatic write_cfg(input logic [3:0] sel, input logic [1:0] mode, input logic [7:0] pt);
        cfg_we     = 1'b1;
        cfg_sel    = sel;
        cfg_mode   = mode;
        cfg_preset = pt;
        step();
        cfg_we     = 1'b0;
    endtask

    task automatic wait_tick();
        for (int n = 0; n < 8; n++) begin
            if (base_tick === 1'b1) break;
            step();
        end
        checkOutput("tick_seen", 32'(base_tick), 32'd1);
    endtask

    task automatic check_q(input string tag, input logic [3:0] exp);
        checkOutput(tag, 32'(tmr_q), 32'(exp));
    endtask

    task automatic check_et(input string tag, input logic [3:0] sel, input logic [7:0] exp);
        rd_sel = sel;
        #1;
        checkOutput(tag, 32'(rd_et), 32'(exp));
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        rst_n      = 1'b0;
        tmr_in     = '0;
        cfg_we     = 1'b0;
        cfg_sel    = '0;
        cfg_mode   = '0;
        cfg_preset = '0;
        rd_sel     = '0;

        // Reset state and prescaler period
        #12;
        checkOutput("rst_base_tick", 32'(base_tick), 32'd0);
        check_q("rst_tmr_q", 4'b0000);
        for (int s = 0; s < 16; s++) begin
            check_et("rst_rd_et", 4'(s), 8'd0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            step();
            checkOutput("tick_period", 32'(base_tick), ((k % 4) == 0) ? 32'd1 : 32'd0);
        end
        check_q("idle_tmr_q", 4'b0000);

        // TON channel 0, PT=3
        write_cfg(4'd0, 2'd1, 8'd3);
        tmr_in[0] = 1'b1;
        wait_tick();
        step();
        check_et("ton_et1", 4'd0, 8'd1);
        check_q("ton_q_t1", 4'b0000);
        wait_tick();
        step();
        check_et("ton_et2", 4'd0, 8'd2);
        check_q("ton_q_t2", 4'b0000);
        wait_tick();
        step();
        check_et("ton_et3", 4'd0, 8'd3);
        check_q("ton_q_t3", 4'b0001);
        wait_tick();
        step();
        check_et("ton_hold", 4'd0, 8'd3);
        check_q("ton_q_hold", 4'b0001);
        applyStimulus(4'b0000);
        check_q("ton_q_drop", 4'b0000);
        check_et("ton_et_drop", 4'd0, 8'd0);

        // TOF channel 1, PT=2
        write_cfg(4'd1, 2'd2, 8'd2);
        check_q("tof_q_cfg", 4'b0000);
        applyStimulus(4'b0010);
        check_q("tof_q_rise", 4'b0010);
        tmr_in[1] = 1'b0;
        wait_tick();
        step();
        check_et("tof_et1", 4'd1, 8'd1);
        check_q("tof_q_t1", 4'b0010);
        step();
        check_q("tof_q_between", 4'b0010);
        wait_tick();
        step();
        check_et("tof_et2", 4'd1, 8'd2);
        check_q("tof_q_t2", 4'b0000);
        applyStimulus(4'b0010);
        check_q("tof_q_rerise", 4'b0010);
        tmr_in[1] = 1'b0;
        wait_tick();
        step();
        check_et("tof_mid_et", 4'd1, 8'd1);
        applyStimulus(4'b0010);
        check_et("tof_retrig_et", 4'd1, 8'd0);
        check_q("tof_retrig_q", 4'b0010);
        write_cfg(4'd1, 2'd0, 8'd0);
        tmr_in[1] = 1'b0;
        check_q("ch1_off_q", 4'b0000);

        // TP channel 2, PT=4
        write_cfg(4'd2, 2'd3, 8'd4);
        applyStimulus(4'b0100);
        check_q("tp_q_start", 4'b0100);
        check_et("tp_et_start", 4'd2, 8'd0);
        tmr_in[2] = 1'b0;
        wait_tick();
        step();
        check_et("tp_et1", 4'd2, 8'd1);
        applyStimulus(4'b0100);
        check_q("tp_q_retrig", 4'b0100);
        check_et("tp_et_retrig", 4'd2, 8'd1);
        for (int t = 2; t <= 4; t++) begin
            wait_tick();
            step();
            check_et("tp_et_count", 4'd2, 8'(t));
            check_q("tp_q_count", (t == 4) ? 4'b0000 : 4'b0100);
        end
        wait_tick();
        step();
        check_et("tp_et_hold", 4'd2, 8'd4);
        check_q("tp_q_hold", 4'b0000);
        applyStimulus(4'b0000);
        check_et("tp_et_clear", 4'd2, 8'd0);

        // Write colliding with the second tick on channel 0
        tmr_in[0] = 1'b1;
        wait_tick();
        step();
        check_et("wr_et_before", 4'd0, 8'd1);
        wait_tick();
        write_cfg(4'd0, 2'd1, 8'd3);
        check_et("wr_et_cleared", 4'd0, 8'd0);
        check_q("wr_q_cleared", 4'b0000);
        wait_tick();
        step();
        check_et("wr_restart", 4'd0, 8'd1);

        // Out-of-range write leaves every channel alone
        write_cfg(4'd7, 2'd3, 8'd9);
        applyStimulus(4'b1001);
        check_q("bad_sel_q", 4'b0000);
        check_et("bad_sel_et0", 4'd0, 8'd1);
        check_et("bad_sel_rd7", 4'd7, 8'd0);

        // TP with PT=0 never pulses
        tmr_in = 4'b0000;
        write_cfg(4'd3, 2'd3, 8'd0);
        applyStimulus(4'b1000);
        check_q("tp0_q_a", 4'b0000);
        step();
        check_q("tp0_q_b", 4'b0000);
        check_et("tp0_et", 4'd3, 8'd0);
        tmr_in = 4'b0000;

        // Asynchronous reset mid-count
        write_cfg(4'd1, 2'd2, 8'd2);
        applyStimulus(4'b0011);
        wait_tick();
        step();
        wait_tick();
        check_q("pre_rst_q", 4'b0010);
        check_et("pre_rst_et", 4'd0, 8'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check_q("async_rst_q", 4'b0000);
        checkOutput("async_rst_tick", 32'(base_tick), 32'd0);
        check_et("async_rst_et", 4'd0, 8'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();
        step();
        check_q("post_rst_q", 4'b0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vslc_timer_bank.md
Name: vslc_timer_bank

Overview:
- Parametrised bank of PLC-style timers for the VSLC core: N independent channels, each configurable as on-delay (TON), off-delay (TOF) or pulse (TP).
- Generalises the core's single fixed-divider timer to a configurable channel count, counter width and per-channel mode.
- Elapsed time advances on a shared base tick derived from the system clock by an internal power-of-two prescaler.
- Sits beside the scan engine. The engine drives channel inputs, writes configuration, and reads Q bits and elapsed time.

Parameters:
- NUM_TIMERS, 4, number of channels (1..16).
- TIMER_WIDTH, 8, width of the preset and elapsed-time counters in bits (2..16).
- TIMER_CLK_DIV, 15, prescaler exponent: one base tick every 2^TIMER_CLK_DIV clk cycles. 0 means a tick every cycle.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- tmr_in  input  NUM_TIMERS  per-channel IN (enable/trigger) bits
- cfg_we  input  1  configuration write strobe, one cycle
- cfg_sel  input  4  channel index for cfg write
- cfg_mode  input  2  0=off, 1=TON, 2=TOF, 3=TP
- cfg_preset  input  TIMER_WIDTH  preset value PT, in ticks
- rd_sel  input  4  channel index for elapsed-time read
- rd_et  output  TIMER_WIDTH  elapsed time ET of channel rd_sel (combinational mux)
- tmr_q  output  NUM_TIMERS  per-channel Q bits, registered
- base_tick  output  1  one-cycle base tick pulse, registered

Behaviour:
- Clock and reset:
  - Single clock domain: clk.
  - Reset: rst_n is asynchronous and active-low.
- Reset values:
  - Prescaler = 0; base_tick = 0; tmr_q = 0.
  - Every channel: mode = 0, PT = 0, ET = 0, prev_in = 0, running = 0.
  - Reset mid-operation aborts all timing immediately; no state survives.
- Prescaler:
  - TIMER_CLK_DIV-bit free-running counter.
  - base_tick = 1 for the cycle after the counter reaches all-ones; period is exactly 2^TIMER_CLK_DIV cycles.
  - TIMER_CLK_DIV = 0: base_tick = 1 every cycle after reset.
- Channel evaluation:
  - Every channel is evaluated each clk using the current tmr_in bit.
  - ET advances only in cycles where base_tick = 1.
  - Q and ET update at the same edge; Q lags IN by 1 clk.
  - ET saturates at PT and never wraps.
- Mode 0 (off): Q = 0, ET = 0.
- Mode 1 (TON):
  - IN = 0: ET <= 0, Q <= 0.
  - IN = 1: on tick, if ET < PT then ET <= ET + 1.
  - Q <= (ET_next == PT).
  - PT = 0: Q rises 1 clk after IN rises.
- Mode 2 (TOF):
  - IN = 1: ET <= 0, Q <= 1.
  - IN = 0 and Q = 1: on tick, ET increments. Q <= 0 when ET_next == PT.
  - PT = 0: Q drops 1 clk after IN falls.
  - After reset, Q stays 0 until the first IN = 1.
- Mode 3 (TP):
  - A rising edge of IN (IN = 1, prev_in = 0) with running = 0 sets running = 1, Q <= 1, ET <= 0.
  - While running: on tick, ET increments. At ET_next == PT, Q <= 0 and running <= 0.
  - Retrigger edges while running are ignored.
  - After completion, ET holds at PT while IN = 1 and clears to 0 once IN = 0 and running = 0.
  - PT = 0: a rising edge produces no pulse (Q stays 0).
- Configuration write:
  - cfg_we = 1 with cfg_sel < NUM_TIMERS loads mode and PT for that channel.
  - The same write clears that channel's ET, Q, running and prev_in.
  - The write takes priority over a simultaneous tick or input event on that channel; other channels are unaffected.
  - cfg_sel >= NUM_TIMERS: the write is ignored.
  - PT changed below the current ET is impossible, since every write clears ET.
- Read:
  - rd_sel >= NUM_TIMERS returns rd_et = 0.

Test Plan:
1. Run with TIMER_CLK_DIV=2, NUM_TIMERS=4, TIMER_WIDTH=8 for the whole plan.
   - Release reset, hold 20 clks -> base_tick pulses every 4 clks.
   - tmr_q = 0 and rd_et = 0 for all rd_sel values.
2. TON on channel 0 with PT=3.
   - Raise tmr_in[0] -> tmr_q[0] = 1 on the clock of the 3rd tick; rd_et reads 3 and holds.
   - Drop tmr_in[0] -> tmr_q[0] = 0 and ET = 0 after 1 clk.
3. TOF on channel 1 with PT=2.
   - Raise tmr_in[1] -> tmr_q[1] = 1 after 1 clk.
   - Drop tmr_in[1] -> tmr_q[1] stays 1 until the 2nd subsequent tick, then 0.
   - Re-raise tmr_in[1] mid-count -> ET = 0 and Q stays 1.
4. TP on channel 2 with PT=4.
   - Pulse tmr_in[2] for 1 clk -> tmr_q[2] high for 4 ticks.
   - A second edge mid-pulse does not extend it.
   - ET holds at 4 until tmr_in[2] = 0, then clears.
5. Write and reset corner cases.
   - cfg_we to channel 0 in the same cycle as its 2nd tick -> ET = 0, Q = 0, count restarts.
   - cfg_sel=7 -> no channel changes.
   - PT=0 TP edge -> no pulse.
   - Assert rst_n low mid-count -> all outputs 0 immediately, with no clk edge required.
